disp_owner_arb: RTL and testbench
=================================

# disp_owner_arb

Two-requester arbiter that shares the single eight-digit seven-segment display controller (`NexysDisplay`) between independent producers. Examples are `seqAuto` and a diagnostics/counter view. It grants display ownership with a level request/grant handshake. Ties are broken round-robin, and a long-holding owner is preempted after a tick-counted hold limit. The selected requester's hex word and digit enables are registered and driven to the display's `HEX_IN`/`DISP_EN`. It sits in `top` between the producers and `NexysDisplay`, and takes its tick from `freq_div`.

## Interface
- `MAX_HOLD`, default 16: ticks an owner may hold while the other requester waits. 0 disables preemption. Range 0..65535.
- `IDLE_HEX`, default 32'h0000_0000: value on `HEX_OUT` when no owner.
- `CLK` in 1: system clock; all state changes on rising edge.
- `CPU_RSTn` in 1: reset, asynchronous, active-low.
- `CE` in 1: one-cycle tick strobe from `freq_div`; advances the hold counter only.
- `REQ` in 2: level requests; bit i is held high by requester i while it wants the display.
- `HEX0`, `HEX1` in 32 each: hex words of requesters 0/1.
- `EN0`, `EN1` in 8 each: digit enables of requesters 0/1.
- `GNT` out 2: one-hot grant, or 00 when idle.
- `HEX_OUT` out 32: to `NexysDisplay` `HEX_IN`.
- `DISP_EN_OUT` out 8: to `NexysDisplay` `DISP_EN`.
- `BUSY` out 1: high when any grant is active.

## Operation
- States: `IDLE`, `OWN0`, `OWN1`.
- Other registers: `last` (1 bit, index of the most recent owner) and `hold` (16-bit counter).
- Reset values:
  - state = `IDLE`, `last` = 1, `hold` = 0.
  - `GNT` = 00, `BUSY` = 0.
  - `HEX_OUT` = `IDLE_HEX`, `DISP_EN_OUT` = 8'h00.
- `IDLE` transitions:
  - `REQ`=01 → `OWN0`.
  - `REQ`=10 → `OWN1`.
  - `REQ`=11 → `OWN(~last)`.
  - `REQ`=00 → stay.
- `OWNx` transitions, in priority order:
  - `REQ[x]`=0: go to `OWN(other)` if `REQ[other]`=1, else `IDLE`. This is a release.
  - `REQ[other]`=1, `MAX_HOLD`≠0 and `hold`==`MAX_HOLD`: go to `OWN(other)`. This is preemption.
  - Otherwise stay.
- On every entry to `OWNx`: `hold` ← 0 and `last` ← x.
- Hold counter in `OWNx`, when not transitioning: `hold` increments on cycles with `CE`=1 and saturates at `MAX_HOLD`.
  - It counts regardless of `REQ[other]`, so a request arriving after a long hold preempts on its first cycle.
- `GNT`/`BUSY` are decoded directly from the state register (glitch-free, no combinational path from `REQ`).
- Data registers, updated every cycle:
  - `OWN0`: `HEX_OUT` ← `HEX0`, `DISP_EN_OUT` ← `EN0`.
  - `OWN1`: `HEX_OUT` ← `HEX1`, `DISP_EN_OUT` ← `EN1`.
  - `IDLE`: `HEX_OUT` ← `IDLE_HEX`, `DISP_EN_OUT` ← 0.
- The non-owner's inputs never reach the outputs.

## Timing
- Request to grant: `REQ[i]` sampled high at edge n (idle, no contention) → `GNT[i]`=1 after edge n.
- Grant to data: `HEX_OUT`/`DISP_EN_OUT` show requester i's data after edge n+1. Data lags `GNT` by exactly one cycle.
- Release: `REQ[x]` low at edge n → `GNT` changes after edge n. Owner data stops after edge n+1.
- Handover: the direct `OWN0`↔`OWN1` handover has no idle cycle. `GNT` never shows 11.
- Preemption: occurs on the first edge with `hold`==`MAX_HOLD` and `REQ[other]`=1. That is ≥`MAX_HOLD` `CE` pulses after grant.
- `CE` coincident with a transition: ignored; `hold` is cleared instead.
- Mid-operation reset: `CPU_RSTn` low forces all reset values immediately, without waiting for a clock. The first grant after reset goes to requester 0 on a tie.

## Test plan
- Reset: hold `CPU_RSTn`=0 with `REQ`=11 → `GNT`=00, `HEX_OUT`=`IDLE_HEX`, `DISP_EN_OUT`=00. Release reset → `GNT`=01 after 1 edge. `HEX_OUT`=`HEX0` (e.g. 32'h1234_5678) after 2 edges.
- Single requester: `REQ`=10, `HEX1`=32'hDEAD_BEEF, `EN1`=8'h0F → `GNT`=10, `BUSY`=1, then `HEX_OUT`=DEADBEEF, `DISP_EN_OUT`=0F. Drop `REQ` → `GNT`=00, then `DISP_EN_OUT`=00.
- Preemption, `MAX_HOLD`=4: `REQ`=01, then `REQ`=11 with `CE` pulsed every 10 cycles → `GNT` switches to 10 on the edge after the 4th `CE` pulse. Then back to 01 after 4 more `CE` pulses. Verify alternation continues.
- `MAX_HOLD`=0: `REQ`=11 for 1000 cycles with `CE` every 10 cycles → `GNT` stays 01 throughout.
- Release handover: owner 0 drops `REQ` while `REQ[1]`=1 → `GNT` goes 01→10 in one edge, never 00 or 11. `HEX_OUT` never shows `HEX1` while `GNT`=01.
- Async reset mid-grant: assert `CPU_RSTn`=0 between clock edges while `GNT`=10 → outputs go to reset values before the next edge.

Source files
------------

// File: rtl/disp_owner_arb_if.sv
// Display-sharing bundle between two producers and the owner arbiter.
// Producers drive requests and data; the arbiter returns grant and muxed data.
interface disp_owner_arb_if;
   logic [1:0]  REQ;
   logic [31:0] HEX0;
   logic [31:0] HEX1;
   logic [7:0]  EN0;
   logic [7:0]  EN1;
   logic [1:0]  GNT;
   logic [31:0] HEX_OUT;
   logic [7:0]  DISP_EN_OUT;
   logic        BUSY;

   modport master (
      output REQ, HEX0, HEX1, EN0, EN1,
      input  GNT, HEX_OUT, DISP_EN_OUT, BUSY
   );

   modport slave (
      input  REQ, HEX0, HEX1, EN0, EN1,
      output GNT, HEX_OUT, DISP_EN_OUT, BUSY
   );
endinterface

// File: rtl/disp_owner_arb.sv
// Two-requester round-robin owner arbiter for the seven-segment display,
// with tick-counted preemption of a long-holding owner.
module disp_owner_arb #(
   parameter int          MAX_HOLD = 16,
   parameter logic [31:0] IDLE_HEX = 32'h0000_0000
) (
   input logic              CLK,
   input logic              CPU_RSTn,
   input logic              CE,
   disp_owner_arb_if.slave  disp
);
   localparam logic [15:0] MH      = 16'(MAX_HOLD);
   localparam logic        PREEMPT = (MAX_HOLD != 0);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t      state, state_nxt;
   logic        last, last_nxt;
   logic [15:0] hold, hold_nxt;
   logic [31:0] hex_q;
   logic [7:0]  en_q;

   always_ff @(posedge CLK or negedge CPU_RSTn) begin
      if (!CPU_RSTn) begin
         state <= IDLE;
         last  <= 1'b1;
         hold  <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         hold  <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      hold_nxt  = hold;
      unique case (state)
         IDLE: begin
            unique case (disp.REQ)
               2'b01:   state_nxt = OWN0;
               2'b10:   state_nxt = OWN1;
               2'b11:   state_nxt = last ? OWN0 : OWN1;
               default: state_nxt = IDLE;
            endcase
         end
         OWN0: begin
            if (!disp.REQ[0])
               state_nxt = disp.REQ[1] ? OWN1 : IDLE;
            else if (disp.REQ[1] && PREEMPT && hold == MH)
               state_nxt = OWN1;
         end
         OWN1: begin
            if (!disp.REQ[1])
               state_nxt = disp.REQ[0] ? OWN0 : IDLE;
            else if (disp.REQ[0] && PREEMPT && hold == MH)
               state_nxt = OWN0;
         end
         default: state_nxt = IDLE;
      endcase
      // a new owner always starts with a fresh hold budget
      if (state_nxt != state && state_nxt != IDLE) begin
         hold_nxt = '0;
         last_nxt = (state_nxt == OWN1);
      end else if (state_nxt == state && state != IDLE &&
                   CE && hold != MH) begin
         hold_nxt = hold + 16'd1;
      end
   end

   always_ff @(posedge CLK or negedge CPU_RSTn) begin
      if (!CPU_RSTn) begin
         hex_q <= IDLE_HEX;
         en_q  <= 8'h00;
      end else begin
         unique case (state)
            OWN0: begin
               hex_q <= disp.HEX0;
               en_q  <= disp.EN0;
            end
            OWN1: begin
               hex_q <= disp.HEX1;
               en_q  <= disp.EN1;
            end
            default: begin
               hex_q <= IDLE_HEX;
               en_q  <= 8'h00;
            end
         endcase
      end
   end

   assign disp.GNT         = {state == OWN1, state == OWN0};
   assign disp.BUSY        = (state != IDLE);
   assign disp.HEX_OUT     = hex_q;
   assign disp.DISP_EN_OUT = en_q;
endmodule

// File: tb/tb_disp_owner_arb.sv
// Scoreboard bench for disp_owner_arb: two instances (hold limit 4 and 0)
// share one stimulus stream and are checked against an owner-level model.
module tb_disp_owner_arb;
   localparam logic [31:0] IDLE_A = 32'h0000_0000;
   localparam logic [31:0] IDLE_B = 32'hCAFE_0000;

   logic        CLK = 1'b0;
   logic        rst_n = 1'b0;
   logic        ce = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [31:0] hex0 = '0, hex1 = '0;
   logic [7:0]  en0 = '0, en1 = '0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   disp_owner_arb_if ifa ();
   disp_owner_arb_if ifb ();

   assign ifa.REQ = req;
   assign ifa.HEX0 = hex0;
   assign ifa.HEX1 = hex1;
   assign ifa.EN0 = en0;
   assign ifa.EN1 = en1;
   assign ifb.REQ = req;
   assign ifb.HEX0 = hex0;
   assign ifb.HEX1 = hex1;
   assign ifb.EN0 = en0;
   assign ifb.EN1 = en1;

   disp_owner_arb #(.MAX_HOLD(4), .IDLE_HEX(IDLE_A)) dut_a (
      .CLK(CLK), .CPU_RSTn(rst_n), .CE(ce), .disp(ifa.slave)
   );
   disp_owner_arb #(.MAX_HOLD(0), .IDLE_HEX(IDLE_B)) dut_b (
      .CLK(CLK), .CPU_RSTn(rst_n), .CE(ce), .disp(ifb.slave)
   );

   // owner: -1 none, 0 or 1; hex/en are the registered display outputs
   typedef struct {
      int          owner;
      int          last;
      int          hold;
      logic [31:0] hex;
      logic [7:0]  en;
   } mst_t;

   typedef struct {
      logic [1:0]  gnt;
      logic [31:0] hex;
      logic [7:0]  en;
      logic        busy;
   } exp_t;

   mst_t ma, mb;
   exp_t qa[$], qb[$];

   function automatic mst_t mreset(logic [31:0] idle);
      mst_t s;
      s.owner = -1; s.last = 1; s.hold = 0; s.hex = idle; s.en = 8'h00;
      return s;
   endfunction

   function automatic mst_t mstep(mst_t s, int mh, logic [31:0] idle,
                                  logic [1:0] r, logic c);
      mst_t n = s;
      int nxt = s.owner;
      int o;
      n.hex = (s.owner == 0) ? hex0 : (s.owner == 1) ? hex1 : idle;
      n.en  = (s.owner == 0) ? en0  : (s.owner == 1) ? en1  : 8'h00;
      if (s.owner < 0) begin
         if (r == 2'b01) nxt = 0;
         else if (r == 2'b10) nxt = 1;
         else if (r == 2'b11) nxt = 1 - s.last;
      end else begin
         o = 1 - s.owner;
         if (!r[s.owner]) nxt = r[o] ? o : -1;
         else if (r[o] && mh != 0 && s.hold == mh) nxt = o;
      end
      if (nxt >= 0 && nxt != s.owner) begin
         n.hold = 0;
         n.last = nxt;
      end else if (nxt >= 0 && nxt == s.owner && c && s.hold < mh) begin
         n.hold = s.hold + 1;
      end
      n.owner = nxt;
      return n;
   endfunction

   function automatic exp_t mexp(mst_t s);
      exp_t e;
      e.gnt  = (s.owner == 0) ? 2'b01 : (s.owner == 1) ? 2'b10 : 2'b00;
      e.busy = (s.owner >= 0);
      e.hex  = s.hex;
      e.en   = s.en;
      return e;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         ma = mreset(IDLE_A);
         mb = mreset(IDLE_B);
         qa.delete();
         qb.delete();
      end else begin
         ma = mstep(ma, 4, IDLE_A, req, ce);
         mb = mstep(mb, 0, IDLE_B, req, ce);
         qa.push_back(mexp(ma));
         qb.push_back(mexp(mb));
      end
   end

   always @(negedge CLK) begin
      exp_t e;
      if (!rst_n) begin
         chk("rst_gnt_a", 32'(ifa.GNT), 32'h0);
         chk("rst_hex_a", ifa.HEX_OUT, IDLE_A);
         chk("rst_en_b", 32'(ifb.DISP_EN_OUT), 32'h0);
         chk("rst_hex_b", ifb.HEX_OUT, IDLE_B);
      end else begin
         if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("gnt_a", 32'(ifa.GNT), 32'(e.gnt));
            chk("busy_a", 32'(ifa.BUSY), 32'(e.busy));
            chk("hex_a", ifa.HEX_OUT, e.hex);
            chk("en_a", 32'(ifa.DISP_EN_OUT), 32'(e.en));
         end
         if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("gnt_b", 32'(ifb.GNT), 32'(e.gnt));
            chk("busy_b", 32'(ifb.BUSY), 32'(e.busy));
            chk("hex_b", ifb.HEX_OUT, e.hex);
            chk("en_b", 32'(ifb.DISP_EN_OUT), 32'(e.en));
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   initial begin
      int cnt, since, seen, sw_a, bad_b;
      logic [1:0] pg;

      // reset held with a tie pending
      req = 2'b11;
      hex0 = 32'h1234_5678; en0 = 8'hFF;
      hex1 = 32'h8765_4321; en1 = 8'hAA;
      repeat (3) step();
      #1 rst_n = 1'b1;
      step();
      chk("first_gnt", 32'(ifa.GNT), 32'h1);
      step();
      chk("first_hex", ifa.HEX_OUT, 32'h1234_5678);

      // preemption with CE every 10 cycles; no CE has been seen yet
      cnt = 0; since = 0; seen = 0; sw_a = 0; bad_b = 0;
      pg = ifa.GNT;
      for (int i = 0; i < 1000; i++) begin
         step();
         since = ce ? 0 : since + 1;
         if (ce) cnt++;
         if (ifa.GNT != pg) sw_a++;
         if (seen == 0 && ifa.GNT == 2'b10) begin
            seen = 1;
            chk("preempt_pulses", 32'(cnt), 32'd4);
            chk("preempt_lag", 32'(since), 32'd1);
         end
         if (ifb.GNT != 2'b01) bad_b++;
         pg = ifa.GNT;
         ce = (i % 10 == 0);
      end
      ce = 1'b0;
      chk("preempt_seen", 32'(seen), 32'd1);
      chk("alternation", 32'(sw_a >= 20), 32'd1);
      chk("nohold_b_stays", 32'(bad_b), 32'd0);

      // single requester 1 from idle
      req = 2'b00;
      repeat (3) step();
      hex1 = 32'hDEAD_BEEF; en1 = 8'h0F; req = 2'b10;
      step();
      chk("single_gnt", 32'(ifa.GNT), 32'h2);
      chk("single_busy", 32'(ifa.BUSY), 32'h1);
      step();
      chk("single_hex", ifa.HEX_OUT, 32'hDEAD_BEEF);
      chk("single_en", 32'(ifa.DISP_EN_OUT), 32'h0F);

      // asynchronous reset between edges while owner 1 holds
      step();
      #1 rst_n = 1'b0;
      #1;
      chk("async_gnt", 32'(ifa.GNT), 32'h0);
      chk("async_busy", 32'(ifa.BUSY), 32'h0);
      chk("async_hex", ifa.HEX_OUT, IDLE_A);
      chk("async_en", 32'(ifa.DISP_EN_OUT), 32'h0);
      step();
      #1 rst_n = 1'b1;
      req = 2'b00;
      step();
      chk("drop_gnt", 32'(ifa.GNT), 32'h0);

      // random levels, ticks and data against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(7) == 0) req[0] = ~req[0];
         if ($urandom_range(7) == 0) req[1] = ~req[1];
         ce = ($urandom_range(3) == 0);
         hex0 = $urandom; hex1 = $urandom;
         en0 = 8'($urandom); en1 = 8'($urandom);
         step();
         n_cmp++;
         if (ifa.GNT == 2'b11 || ifb.GNT == 2'b11) begin
            n_err++;
            $display("FAIL gnt_onehot: got %b/%b expected not 11",
                     ifa.GNT, ifb.GNT);
         end
      end
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
